// File: rtl/syn_lb_arb_pkg.sv
// Shared types and helpers for the local-bus round-robin arbiter.
//   state_e : arbiter FSM states
//   op_e    : latched operation of the in-flight transaction
//   idx_w() : bit width needed to count or index 0..n-1 (at least 1)
package syn_lb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    HOLD = 3'd4
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/syn_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr_i, wrapping around. ptr_i must be < N.
//   req_i : request vector
//   ptr_i : priority start index
//   gnt_o : one-hot grant
//   idx_o : index of the granted requester
//   any_o : at least one request present
module syn_rr_arb
  import syn_lb_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/syn_lb_arb.sv
// Round-robin arbiter sharing one local-bus slave among NUM_MSTRS requesters,
// one transaction in flight. Every output is a register.
//   clk_ir, rst_il          : clock, synchronous active-high reset
//   mst_rd_en/mst_wr_en     : level requests, held until the matching valid
//   mst_addr/mst_wr_data    : packed per-requester address / write data
//   mst_rd_valid/wr_valid   : one-hot completion pulses
//   mst_rd_data             : broadcast read data, held between reads
//   lb_*                    : slave command strobes and completion inputs
//   to_err                  : pulses with a completion forced by timeout
module syn_lb_arb
  import syn_lb_arb_pkg::*;
#(
  parameter int          NUM_MSTRS = 2,
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 8,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] TO_DATA   = 32'hDEAD_DEAD
) (
  input  logic                        clk_ir,
  input  logic                        rst_il,
  input  logic [NUM_MSTRS-1:0]        mst_rd_en,
  input  logic [NUM_MSTRS-1:0]        mst_wr_en,
  input  logic [NUM_MSTRS*ADDR_W-1:0] mst_addr,
  input  logic [NUM_MSTRS*DATA_W-1:0] mst_wr_data,
  output logic [NUM_MSTRS-1:0]        mst_rd_valid,
  output logic [NUM_MSTRS-1:0]        mst_wr_valid,
  output logic [DATA_W-1:0]           mst_rd_data,
  output logic                        lb_rd_en,
  output logic                        lb_wr_en,
  output logic [ADDR_W-1:0]           lb_addr,
  output logic [DATA_W-1:0]           lb_wr_data,
  input  logic                        lb_rd_valid,
  input  logic                        lb_wr_valid,
  input  logic [DATA_W-1:0]           lb_rd_data,
  output logic                        to_err
);

  localparam int                PTR_W   = idx_w(NUM_MSTRS);
  localparam int                CNT_W   = idx_w(TIMEOUT);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TO_DW   = DATA_W'(TO_DATA);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_MSTRS-1:0]   gnt_oh_q, gnt_oh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MSTRS-1:0]   mst_rd_valid_q, mst_rd_valid_d;
  logic [NUM_MSTRS-1:0]   mst_wr_valid_q, mst_wr_valid_d;
  logic [DATA_W-1:0]      mst_rd_data_q, mst_rd_data_d;
  logic                   lb_rd_en_q, lb_rd_en_d;
  logic                   lb_wr_en_q, lb_wr_en_d;
  logic [ADDR_W-1:0]      lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0]      lb_wr_data_q, lb_wr_data_d;
  logic                   to_err_q, to_err_d;

  logic [NUM_MSTRS-1:0]   arb_gnt;
  logic [PTR_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   hit, expire;

  syn_rr_arb #(.N(NUM_MSTRS), .IDX_W(PTR_W)) u_rr (
    .req_i (mst_rd_en | mst_wr_en),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Only the valid matching the latched op completes; the other is ignored.
  assign hit    = (op_q == OP_WR) ? lb_wr_valid : lb_rd_valid;
  assign expire = (cnt_q == TO_LAST);

  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      state_q        <= IDLE;
      op_q           <= OP_RD;
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      gnt_oh_q       <= '0;
      cnt_q          <= '0;
      mst_rd_valid_q <= '0;
      mst_wr_valid_q <= '0;
      mst_rd_data_q  <= '0;
      lb_rd_en_q     <= 1'b0;
      lb_wr_en_q     <= 1'b0;
      lb_addr_q      <= '0;
      lb_wr_data_q   <= '0;
      to_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      gnt_oh_q       <= gnt_oh_d;
      cnt_q          <= cnt_d;
      mst_rd_valid_q <= mst_rd_valid_d;
      mst_wr_valid_q <= mst_wr_valid_d;
      mst_rd_data_q  <= mst_rd_data_d;
      lb_rd_en_q     <= lb_rd_en_d;
      lb_wr_en_q     <= lb_wr_en_d;
      lb_addr_q      <= lb_addr_d;
      lb_wr_data_q   <= lb_wr_data_d;
      to_err_q       <= to_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = CMD;
      CMD:     state_d = WAIT;
      WAIT:    if (hit || expire) state_d = DONE;
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each is computed one cycle ahead of the
  // state in which it must appear (strobe from IDLE, valids from WAIT).
  always_comb begin
    op_d           = op_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_idx_d      = gnt_idx_q;
    gnt_oh_d       = gnt_oh_q;
    cnt_d          = cnt_q;
    mst_rd_valid_d = '0;
    mst_wr_valid_d = '0;
    mst_rd_data_d  = mst_rd_data_q;
    lb_rd_en_d     = 1'b0;
    lb_wr_en_d     = 1'b0;
    lb_addr_d      = lb_addr_q;
    lb_wr_data_d   = lb_wr_data_q;
    to_err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_idx_d    = arb_idx;
          gnt_oh_d     = arb_gnt;
          // Write wins when both are held; the read stays pending.
          op_d         = mst_wr_en[arb_idx] ? OP_WR : OP_RD;
          lb_wr_en_d   = mst_wr_en[arb_idx];
          lb_rd_en_d   = !mst_wr_en[arb_idx];
          lb_addr_d    = mst_addr[arb_idx*ADDR_W +: ADDR_W];
          lb_wr_data_d = mst_wr_data[arb_idx*DATA_W +: DATA_W];
        end
      end
      CMD: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hit || expire) begin
          if (op_q == OP_WR) mst_wr_valid_d = gnt_oh_q;
          else               mst_rd_valid_d = gnt_oh_q;
          // A valid on the final count beats the timeout.
          if (!hit) to_err_d = 1'b1;
          if (op_q == OP_RD) mst_rd_data_d = hit ? lb_rd_data : TO_DW;
        end
      end
      DONE: rr_ptr_d = (gnt_idx_q == PTR_W'(NUM_MSTRS - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
      default: ;
    endcase
  end

  assign mst_rd_valid = mst_rd_valid_q;
  assign mst_wr_valid = mst_wr_valid_q;
  assign mst_rd_data  = mst_rd_data_q;
  assign lb_rd_en     = lb_rd_en_q;
  assign lb_wr_en     = lb_wr_en_q;
  assign lb_addr      = lb_addr_q;
  assign lb_wr_data   = lb_wr_data_q;
  assign to_err       = to_err_q;

endmodule

// File: tb/tb_syn_lb_arb.sv
// Bench for syn_lb_arb: directed steps followed by random rounds, checked
// against a transaction-level model (pending requests, rr pointer, held
// read data, slave latency -> completion cycle).
module tb_syn_lb_arb;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 8;
  localparam logic [DW-1:0] TOD = 32'hDEAD_DEAD;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    mst_rd_en, mst_wr_en, mst_rd_valid, mst_wr_valid;
  logic [N*AW-1:0] mst_addr;
  logic [N*DW-1:0] mst_wr_data;
  logic [DW-1:0]   mst_rd_data, lb_wr_data, lb_rd_data;
  logic [AW-1:0]   lb_addr;
  logic            lb_rd_en, lb_wr_en, lb_rd_valid, lb_wr_valid, to_err;

  syn_lb_arb #(.NUM_MSTRS(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_ir(clk), .rst_il(rst),
    .mst_rd_en(mst_rd_en), .mst_wr_en(mst_wr_en),
    .mst_addr(mst_addr), .mst_wr_data(mst_wr_data),
    .mst_rd_valid(mst_rd_valid), .mst_wr_valid(mst_wr_valid),
    .mst_rd_data(mst_rd_data),
    .lb_rd_en(lb_rd_en), .lb_wr_en(lb_wr_en),
    .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_rd_valid(lb_rd_valid), .lb_wr_valid(lb_wr_valid),
    .lb_rd_data(lb_rd_data), .to_err(to_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit            prd[N], pwr[N];
  logic [AW-1:0] paddr[N];
  logic [DW-1:0] pdata[N];
  int            rr;
  logic [DW-1:0] exp_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      mst_rd_en[i]             = prd[i];
      mst_wr_en[i]             = pwr[i];
      mst_addr[i*AW +: AW]     = paddr[i];
      mst_wr_data[i*DW +: DW]  = pdata[i];
    end
  endtask

  task automatic set_req(input int m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (wr) pwr[m] = 1'b1; else prd[m] = 1'b1;
    paddr[m] = a;
    pdata[m] = d;
    drive_reqs();
  endtask

  task automatic noise();
    lb_rd_valid = 1'($urandom_range(0, 1));
    lb_wr_valid = 1'($urandom_range(0, 1));
    lb_rd_data  = $urandom();
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, to_err}, 0);
    chk("rd_data_hold", mst_rd_data, exp_rd);
  endtask

  // Entered in an IDLE cycle with requests already driven. Slave answers
  // lat cycles after the strobe; lat > TO means it never answers.
  task automatic run_one(input int lat, input logic [DW-1:0] sdata);
    int g;
    bit wr, tmo;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && (prd[(rr + k) % N] || pwr[(rr + k) % N])) g = (rr + k) % N;
    if (g < 0) return;
    wr  = pwr[g];
    tmo = (lat > TO);
    tick();
    chk("strobe_wr", lb_wr_en, wr);
    chk("strobe_rd", lb_rd_en, !wr);
    chk("lb_addr", lb_addr, paddr[g]);
    chk("lb_wr_data", lb_wr_data, pdata[g]);
    chk("cmd_no_valid", {mst_rd_valid, mst_wr_valid, to_err}, 0);
    noise();
    for (int n = 1; n <= (tmo ? TO : lat); n++) begin
      tick();
      chk_quiet("wait_quiet");
      chk("wait_addr", lb_addr, paddr[g]);
      chk("wait_wdata", lb_wr_data, pdata[g]);
      noise();
      if (wr) lb_wr_valid = (n == lat);
      else    lb_rd_valid = (n == lat);
      if (n == lat) lb_rd_data = sdata;
    end
    tick();
    if (!wr) exp_rd = tmo ? TOD : sdata;
    chk("done_rd_valid", mst_rd_valid, wr ? 0 : (1 << g));
    chk("done_wr_valid", mst_wr_valid, wr ? (1 << g) : 0);
    chk("done_to_err", to_err, tmo);
    chk("done_rd_data", mst_rd_data, exp_rd);
    chk("done_no_strobe", {lb_rd_en, lb_wr_en}, 0);
    if (wr) pwr[g] = 1'b0; else prd[g] = 1'b0;
    drive_reqs();
    rr = (g + 1) % N;
    noise();
    tick();
    chk_quiet("hold_quiet");
    noise();
    tick();
    chk_quiet("idle_quiet");
    lb_rd_valid = 1'b0;
    lb_wr_valid = 1'b0;
  endtask

  initial begin
    int npend;
    rst = 1'b1;
    lb_rd_valid = 1'b0; lb_wr_valid = 1'b0; lb_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      prd[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    drive_reqs();
    rr = 0;
    exp_rd = '0;

    // reset state
    tick(); tick();
    chk("rst_pulses", {lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, to_err}, 0);
    chk("rst_lb", {lb_addr, lb_wr_data}, 0);
    chk("rst_rd_data", mst_rd_data, 0);
    rst = 1'b0;

    // single write, slave 2 cycles after strobe
    set_req(0, 1'b1, 8'h10, 32'hA5A5_0001);
    run_one(2, 32'h0);
    // single read, latency 3
    set_req(1, 1'b0, 8'h22, 32'h0);
    run_one(3, 32'h1234_5678);

    // contention: two writers re-requesting immediately must alternate
    set_req(0, 1'b1, 8'h40, 32'h0000_0100);
    set_req(1, 1'b1, 8'h41, 32'h0000_0200);
    for (int t = 0; t < 8; t++) begin
      chk("contend_gnt", (pwr[0] && pwr[1]) ? ((rr == 1) ? 1 : 0) : 2, (t % 2 == 0) ? 0 : 1);
      run_one(1 + (t % 3), 32'h0);
      for (int m = 0; m < 2; m++)
        if (!pwr[m]) set_req(m, 1'b1, 8'(8'h40 + m + 2*t), 32'(256*(m + 1) + t));
    end
    pwr[0] = 1'b0; pwr[1] = 1'b0; drive_reqs();
    tick(); chk_quiet("idle_norq");

    // timeouts: read then write, slave silent
    set_req(2, 1'b0, 8'h77, 32'h0);
    run_one(TO + 5, 32'h0);
    set_req(0, 1'b1, 8'h78, 32'hCAFE_0000);
    run_one(TO + 1, 32'h0);
    // valid on the final count wins over the timeout
    set_req(1, 1'b0, 8'h79, 32'h0);
    run_one(TO, 32'h5A5A_1111);

    // write and read held together: write first, read still pending
    set_req(2, 1'b1, 8'h90, 32'h0000_BEEF);
    set_req(2, 1'b0, 8'h90, 32'h0000_BEEF);
    run_one(1, 32'h0);
    run_one(2, 32'h3333_4444);

    // reset during WAIT: drop txn, rr pointer back to 0
    set_req(0, 1'b1, 8'h01, 32'h1);
    run_one(1, 32'h0);
    set_req(0, 1'b1, 8'h02, 32'h2);
    set_req(1, 1'b0, 8'h03, 32'h0);
    tick();
    chk("pre_rst_gnt", {lb_rd_en, lb_addr}, {1'b1, 8'h03});
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_pulses", {lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, to_err}, 0);
    chk("midrst_lb", {lb_addr, lb_wr_data}, 0);
    chk("midrst_rd_data", mst_rd_data, 0);
    rst = 1'b0;
    rr = 0;
    exp_rd = '0;
    run_one(2, 32'h0);
    run_one(1, 32'h7777_8888);

    // random rounds
    for (int r = 0; r < 40; r++) begin
      npend = 0;
      for (int m = 0; m < N; m++) npend += int'(prd[m] | pwr[m]);
      if (npend == 0 && $urandom_range(0, 3) == 0) begin
        tick(); chk_quiet("rand_idle");
      end
      for (int m = 0; m < N; m++)
        if (!prd[m] && !pwr[m] && $urandom_range(0, 1) == 1) begin
          set_req(m, 1'($urandom_range(0, 1)), 8'($urandom()), $urandom());
          if ($urandom_range(0, 3) == 0) begin
            if (prd[m]) pwr[m] = 1'b1; else prd[m] = 1'b1;
            drive_reqs();
          end
        end
      npend = 0;
      for (int m = 0; m < N; m++) npend += int'(prd[m] | pwr[m]);
      if (npend == 0) set_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 8'($urandom()), $urandom());
      run_one($urandom_range(1, TO + 2), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
